// File: rtl/serial_addsub.sv
// serial_addsub -- digit-serial adder/subtractor.
//
// Computes a + b or a - b over WIDTH bits, DIGIT_W bits per clock, with one
// DIGIT_W-bit adder. Subtraction is done as a + ~b + 1: the B operand is
// inverted at acceptance and the carry register is preloaded with 1.
//
// Optional build macro: SERIAL_ADDSUB_SAT_EN
//   defined   -> on signed overflow the result saturates to the most
//                negative / most positive value (carry/overflow stay raw,
//                zero follows the saturated result)
//   undefined -> result wraps modulo 2^WIDTH
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   in_valid / in_ready   operation request handshake (ready only in IDLE)
//   a, b, sub             operands and operation select (1 = a - b)
//   out_valid / out_ready result handshake (valid only in DONE)
//   result                a +/- b (wrapped or saturated)
//   carry                 add: carry out of MSB; sub: 1 = no borrow
//   overflow              two's-complement signed overflow
//   zero                  result == 0
//   busy                  high while digits are being processed
module serial_addsub #(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam int NUM_DIGITS = WIDTH / DIGIT_W;
  localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

  generate
    if (WIDTH < 2 || DIGIT_W < 1 || DIGIT_W > WIDTH || (WIDTH % DIGIT_W) != 0) begin : g_bad_params
      $error("serial_addsub: illegal WIDTH=%0d / DIGIT_W=%0d", WIDTH, DIGIT_W);
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] op_a_reg;
  logic [WIDTH-1:0] op_b_reg;     // already XORed with sub
  logic             carry_reg;    // running carry between digits
  logic [CNT_W-1:0] cnt_reg;
  logic             a_msb_reg;
  logic             bx_msb_reg;
  logic [WIDTH-1:0] result_reg;
  logic             carry_out_reg;
  logic             overflow_reg;
  logic             zero_reg;

  logic [DIGIT_W:0] digit_sum;
  logic [WIDTH-1:0] raw_result;   // accumulated sum including this digit
  logic             raw_ovf;
  logic [WIDTH-1:0] final_result;
  logic             last_digit;

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  assign last_digit = (cnt_reg == LAST_DIGIT);

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        busy = 1'b1;
        if (last_digit) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Digit adder and result assembly
  // ---------------------------------------------------------------------
  always_comb begin
    digit_sum = {1'b0, op_a_reg[DIGIT_W-1:0]}
              + {1'b0, op_b_reg[DIGIT_W-1:0]}
              + {{DIGIT_W{1'b0}}, carry_reg};
  end

  // The sum is built LSB digit first by shifting new digits in from the top,
  // so after NUM_DIGITS steps the first digit lands at bit 0. Only the upper
  // WIDTH-DIGIT_W bits need to be held between cycles.
  generate
    if (DIGIT_W == WIDTH) begin : g_single_digit
      assign raw_result = digit_sum[DIGIT_W-1:0];
    end else begin : g_multi_digit
      logic [WIDTH-DIGIT_W-1:0] acc_reg;

      assign raw_result = {digit_sum[DIGIT_W-1:0], acc_reg};

      always_ff @(posedge clock) begin
        if (reset) begin
          acc_reg <= '0;
        end else if (state_reg == ST_BUSY) begin
          acc_reg <= raw_result[WIDTH-1:DIGIT_W];
        end
      end
    end
  endgenerate

  // Overflow only makes sense on the last digit, when raw_result is complete.
  assign raw_ovf = (a_msb_reg == bx_msb_reg) && (raw_result[WIDTH-1] != a_msb_reg);

`ifdef SERIAL_ADDSUB_SAT_EN
  logic [WIDTH-1:0] sat_value;

  // Both operands share a sign when overflow occurs, so a_msb picks the rail.
  assign sat_value    = a_msb_reg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign final_result = raw_ovf ? sat_value : raw_result;
`else
  assign final_result = raw_result;
`endif

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      carry_reg     <= 1'b0;
      cnt_reg       <= '0;
      a_msb_reg     <= 1'b0;
      bx_msb_reg    <= 1'b0;
      result_reg    <= '0;
      carry_out_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      zero_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            op_a_reg   <= a;
            op_b_reg   <= b ^ {WIDTH{sub}};
            carry_reg  <= sub;
            cnt_reg    <= '0;
            a_msb_reg  <= a[WIDTH-1];
            bx_msb_reg <= b[WIDTH-1] ^ sub;
          end
        end
        ST_BUSY: begin
          op_a_reg  <= op_a_reg >> DIGIT_W;
          op_b_reg  <= op_b_reg >> DIGIT_W;
          carry_reg <= digit_sum[DIGIT_W];
          cnt_reg   <= cnt_reg + 1'b1;
          // Outputs change only when the operation completes, so they hold
          // the previous answer throughout BUSY and stay frozen in DONE.
          if (last_digit) begin
            result_reg    <= final_result;
            carry_out_reg <= digit_sum[DIGIT_W];
            overflow_reg  <= raw_ovf;
            zero_reg      <= (final_result == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result   = result_reg;
  assign carry    = carry_out_reg;
  assign overflow = overflow_reg;
  assign zero     = zero_reg;

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised, multi-cycle adder/subtractor. Computes A + B or A - B over WIDTH bits, DIGIT_W bits per clock, using a single DIGIT_W-bit adder with two's-complement subtract (B XOR sub, carry-in = sub).
- Sits between key/register inputs and LED/7-segment result displays.
- Uses valid/ready handshakes on input and output.
- Reports carry/no-borrow, signed overflow and zero flags.

Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 2.
- DIGIT_W, 2, bits processed per clock; must be 1..WIDTH and divide WIDTH exactly. Violation is an elaboration-time $error.
- NUM_DIGITS (localparam), WIDTH/DIGIT_W, number of BUSY cycles.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept; high only in IDLE
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0 = A + B, 1 = A - B
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  A ± B, wrapped (or saturated, see feature)
- carry  output  1  add: carry out of MSB; sub: 1 = no borrow (A >= B unsigned)
- overflow  output  1  two's-complement signed overflow
- zero  output  1  result == 0
- busy  output  1  state == BUSY

Behaviour:
- Reset: the block has one clock; reset is synchronous and active-high.
  - On reset: state IDLE, digit counter 0, result/carry/overflow/zero = 0, out_valid = 0, busy = 0.
  - in_ready = 1 from the first cycle after reset.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at an edge:
    - latch a and b XOR {WIDTH{sub}};
    - carry register <= sub;
    - counter <= 0;
    - save a[MSB] and (b^sub)[MSB] for the overflow calculation;
    - go to BUSY.
- BUSY (one digit per cycle):
  - Each cycle: {c, s} = a_digit + b_digit + carry, LSB digit first.
  - Shift s into the result register from the top. Shift the operand registers right by DIGIT_W.
  - carry register <= c. counter++.
  - After NUM_DIGITS BUSY cycles, go to DONE.
- DONE:
  - out_valid = 1. result/carry/overflow/zero stay stable until an edge with out_ready = 1.
  - At that edge: go to IDLE, out_valid = 0.
  - in_ready rises the next cycle; a new operation is never accepted in the same cycle as out_valid && out_ready.
- Latency:
  - Accept at edge k → out_valid = 1 after edge k + NUM_DIGITS.
  - With DIGIT_W == WIDTH: 1 cycle.
  - Minimum back-to-back period: NUM_DIGITS + 2 cycles.
- Flag rules:
  - carry = final carry out.
  - overflow = (a_msb == bx_msb) && (raw_result[MSB] != a_msb).
  - zero computed from the output result, registered together with it.
- Input timing: a/b/sub are sampled only at acceptance. Changes during BUSY/DONE are ignored. in_valid during BUSY/DONE is ignored and not queued.
- Reset mid-operation (BUSY or DONE): operation aborted, no out_valid, IDLE next cycle.
- out_ready is don't-care outside DONE.

Optional Feature:
- Macro: SERIAL_ADDSUB_SAT_EN.
- Defined:
  - When overflow = 1 on entering DONE, result = signed saturated value: 1000…0 if a_msb = 1, else 0111…1.
  - Applied in the same cycle out_valid rises; no extra latency.
  - carry/overflow still report raw values; zero is taken from the saturated result.
- Undefined: result wraps modulo 2^WIDTH; no saturation logic.

Test Plan (WIDTH=8, DIGIT_W=2 unless noted):
1. a=0x05, b=0x03, sub=0, out_ready=1 → out_valid exactly 4 edges after accept; result=0x08, carry=0, overflow=0, zero=0; in_ready back to 1 two cycles later.
2. a=0x03, b=0x05, sub=1 → result=0xFE, carry=0 (borrow), overflow=0. Then a=0x05, b=0x03, sub=1 → 0x02, carry=1.
3. a=0x7F, b=0x01, sub=0 → overflow=1, carry=0; result=0x80 (wrap) or 0x7F with SERIAL_ADDSUB_SAT_EN. Also a=0x80, b=0x01, sub=1 → overflow=1, carry=1; result=0x7F (wrap) or 0x80 (sat).
4. a=0xFF, b=0x01, sub=0 → result=0x00, carry=1, zero=1, overflow=0.
5. Backpressure and reset:
   - Hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0.
   - Pulse in_valid with new operands during BUSY → ignored; result matches the first operation.
   - Assert reset in the 2nd BUSY cycle → out_valid never rises, in_ready=1 the cycle after reset.
6. Sweep parameters (WIDTH, DIGIT_W) ∈ {(8,1), (8,8), (12,3)} over all-random operands and both sub values → result/flags match a reference model; latency = WIDTH/DIGIT_W.
